cv_mem_arbiter: RTL and testbench

Single-port memory arbiter for the ColecoVision console. Shares one external byte-wide memory between the CPU (cartridge ROM reads and CPU RAM reads/writes) and the host ROM loader. Sits between the console top level and the memory controller. Stretches CPU bus cycles through the console's `wait_cart` input until each access completes.

---
 rtl/cv_mem_arbiter.sv | 124 ++++++++++++
 tb/tb_cv_mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv_mem_arbiter.sv
// cv_mem_arbiter: shares one byte-wide external memory between the CPU
// (cartridge ROM reads, CPU RAM reads/writes) and the host ROM loader.
// CPU cycles are stretched through wait_n_o until their access completes;
// the loader has a single-entry write buffer.
module cv_mem_arbiter #(
  parameter int MEM_AW = 21
) (
  input  logic              clk_i,
  input  logic              reset_n_s,
  input  logic              cart_rd_i,
  input  logic [19:0]       cart_a_i,
  input  logic              ram_ce_n_i,
  input  logic              ram_rd_n_i,
  input  logic              ram_we_n_i,
  input  logic [14:0]       ram_a_i,
  input  logic [7:0]        ram_d_i,
  output logic [7:0]        cpu_d_o,
  output logic              wait_n_o,
  input  logic              ld_wr_i,
  input  logic [MEM_AW-1:0] ld_a_i,
  input  logic [7:0]        ld_d_i,
  output logic              ld_busy_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [MEM_AW-1:0] mem_a_o,
  output logic [7:0]        mem_d_o,
  input  logic              mem_ack_i,
  input  logic [7:0]        mem_d_i
);

  typedef enum logic [1:0] {IDLE, CPU_ACC, LD_ACC} state_t;

  state_t            state;
  logic              served;
  logic              last_ld;   // 1 = loader won the most recent grant
  logic [MEM_AW-1:0] ld_a;
  logic [7:0]        ld_d;

  logic              ram_sel;
  logic              cpu_sel;
  logic              cpu_pend;
  logic              grant_cpu;
  logic [MEM_AW-1:0] cpu_a;
  logic              cpu_we;

  assign ram_sel   = ~ram_ce_n_i & (~ram_rd_n_i | ~ram_we_n_i);
  assign cpu_sel   = cart_rd_i | ram_sel;
  assign cpu_pend  = cpu_sel & ~served;
  // Combinational so the Z80 sees wait in the very cycle its strobe rises.
  assign wait_n_o  = ~cpu_pend;
  // On a tie the requester that did not win last gets the memory.
  assign grant_cpu = cpu_pend & (~ld_busy_o | last_ld);

  // Cartridge read beats a simultaneous RAM select.
  assign cpu_a  = cart_rd_i ? {{(MEM_AW-20){1'b0}}, cart_a_i}
                            : {1'b1, {(MEM_AW-16){1'b0}}, ram_a_i};
  assign cpu_we = ~cart_rd_i & ~ram_we_n_i;

  // Arbitration FSM, loader buffer and registered memory/CPU outputs.
  always_ff @(posedge clk_i or negedge reset_n_s) begin
    if (!reset_n_s) begin
      state     <= IDLE;
      mem_req_o <= 1'b0;
      mem_we_o  <= 1'b0;
      mem_a_o   <= '0;
      mem_d_o   <= '0;
      cpu_d_o   <= 8'hFF;
      ld_busy_o <= 1'b0;
      ld_a      <= '0;
      ld_d      <= '0;
      served    <= 1'b0;
      last_ld   <= 1'b1;
    end else begin
      if (!cpu_sel) served <= 1'b0;

      // A pulse while the buffer is occupied is dropped.
      if (ld_wr_i && !ld_busy_o) begin
        ld_busy_o <= 1'b1;
        ld_a      <= ld_a_i;
        ld_d      <= ld_d_i;
      end

      case (state)
        IDLE: begin
          if (grant_cpu) begin
            state     <= CPU_ACC;
            mem_req_o <= 1'b1;
            mem_a_o   <= cpu_a;
            mem_we_o  <= cpu_we;
            if (cpu_we) mem_d_o <= ram_d_i;
            last_ld   <= 1'b0;
          end else if (ld_busy_o) begin
            state     <= LD_ACC;
            mem_req_o <= 1'b1;
            mem_a_o   <= ld_a;
            mem_we_o  <= 1'b1;
            mem_d_o   <= ld_d;
            last_ld   <= 1'b1;
          end
        end
        CPU_ACC: begin
          if (mem_ack_i) begin
            state     <= IDLE;
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            if (!mem_we_o) cpu_d_o <= mem_d_i;
            // If the strobe already went away, the next one gets a fresh access.
            if (cpu_sel) served <= 1'b1;
          end
        end
        LD_ACC: begin
          if (mem_ack_i) begin
            state     <= IDLE;
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            ld_busy_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cv_mem_arbiter.sv
// Directed bench for cv_mem_arbiter: a vector table of single CPU accesses
// plus hand-written loader, tie, reset and strobe-drop sequences. A small
// memory responder acks each request after a programmable delay.
module tb_cv_mem_arbiter;
  logic        clk_i = 1'b0;
  logic        reset_n_s;
  logic        cart_rd_i;
  logic [19:0] cart_a_i;
  logic        ram_ce_n_i, ram_rd_n_i, ram_we_n_i;
  logic [14:0] ram_a_i;
  logic [7:0]  ram_d_i;
  logic [7:0]  cpu_d_o;
  logic        wait_n_o;
  logic        ld_wr_i;
  logic [20:0] ld_a_i;
  logic [7:0]  ld_d_i;
  logic        ld_busy_o;
  logic        mem_req_o, mem_we_o;
  logic [20:0] mem_a_o;
  logic [7:0]  mem_d_o;
  logic        mem_ack_i;
  logic [7:0]  mem_d_i;

  cv_mem_arbiter #(.MEM_AW(21)) dut (
    .clk_i(clk_i), .reset_n_s(reset_n_s),
    .cart_rd_i(cart_rd_i), .cart_a_i(cart_a_i),
    .ram_ce_n_i(ram_ce_n_i), .ram_rd_n_i(ram_rd_n_i), .ram_we_n_i(ram_we_n_i),
    .ram_a_i(ram_a_i), .ram_d_i(ram_d_i),
    .cpu_d_o(cpu_d_o), .wait_n_o(wait_n_o),
    .ld_wr_i(ld_wr_i), .ld_a_i(ld_a_i), .ld_d_i(ld_d_i), .ld_busy_o(ld_busy_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_a_o(mem_a_o), .mem_d_o(mem_d_o),
    .mem_ack_i(mem_ack_i), .mem_d_i(mem_d_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // responder state
  int          dly = 0;
  logic [7:0]  rdata = 8'h00;
  int          req_cnt = 0;
  logic [20:0] log_a = '0;
  logic        log_we = 1'b0;
  logic [7:0]  log_d = '0;
  logic [20:0] grant_q[$];

  // Memory responder: acks after dly cycles of mem_req_o, logs each access.
  initial begin
    int cnt;
    cnt = 0;
    mem_ack_i = 1'b0;
    mem_d_i = 8'h00;
    forever begin
      @(negedge clk_i);
      if (mem_ack_i) begin
        mem_ack_i = 1'b0;
        cnt = 0;
      end else if (mem_req_o) begin
        if (cnt >= dly) begin
          mem_ack_i = 1'b1;
          mem_d_i = rdata;
          req_cnt++;
          log_a = mem_a_o;
          log_we = mem_we_o;
          log_d = mem_d_o;
          grant_q.push_back(mem_a_o);
        end else cnt++;
      end else cnt = 0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk_i);
    #2;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic cpu_idle();
    cart_rd_i = 1'b0;
    ram_ce_n_i = 1'b1;
    ram_rd_n_i = 1'b1;
    ram_we_n_i = 1'b1;
  endtask

  // kind: 0 cart read, 1 RAM read, 2 RAM write, 3 cart read + RAM read
  task automatic cpu_go(input int kind, input logic [19:0] ca, input logic [14:0] ra,
                        input logic [7:0] wd, output int wc);
    cart_rd_i  = (kind == 0 || kind == 3);
    cart_a_i   = ca;
    ram_ce_n_i = !(kind >= 1);
    ram_rd_n_i = !(kind == 1 || kind == 3);
    ram_we_n_i = !(kind == 2);
    ram_a_i    = ra;
    ram_d_i    = wd;
    #1;
    wc = 0;
    for (int n = 0; n < 60; n++) begin
      if (wait_n_o) break;
      wc++;
      tick();
    end
  endtask

  typedef struct {
    int          kind;
    logic [19:0] ca;
    logic [14:0] ra;
    logic [7:0]  wd;
    int          dl;
    logic [7:0]  rd;
    logic [20:0] ea;
    logic        ewe;
    logic [7:0]  ecd;
    int          ewait;
  } vec_t;

  vec_t tv[6];

  initial begin
    int wc, c0, q0;
    tv[0] = '{0, 20'h01234, 15'h0000, 8'h00, 3, 8'h5A, 21'h001234, 1'b0, 8'h5A, 5};
    tv[1] = '{2, 20'h00000, 15'h7FFF, 8'hA5, 0, 8'hEE, 21'h107FFF, 1'b1, 8'h5A, 2};
    tv[2] = '{1, 20'h00000, 15'h0010, 8'h00, 1, 8'h3C, 21'h100010, 1'b0, 8'h3C, 3};
    tv[3] = '{0, 20'hFFFFF, 15'h0000, 8'h00, 2, 8'hC3, 21'h0FFFFF, 1'b0, 8'hC3, 4};
    tv[4] = '{3, 20'h00ABC, 15'h1234, 8'h00, 1, 8'h77, 21'h000ABC, 1'b0, 8'h77, 3};
    tv[5] = '{1, 20'h00000, 15'h0000, 8'h00, 0, 8'h00, 21'h100000, 1'b0, 8'h00, 2};

    reset_n_s = 1'b0;
    cpu_idle();
    cart_a_i = '0; ram_a_i = '0; ram_d_i = '0;
    ld_wr_i = 1'b0; ld_a_i = '0; ld_d_i = '0;
    tick(); tick();
    reset_n_s = 1'b1;
    tick();

    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_mem_we", mem_we_o, 0);
    chk("rst_mem_a", mem_a_o, 0);
    chk("rst_mem_d", mem_d_o, 0);
    chk("rst_cpu_d", cpu_d_o, 8'hFF);
    chk("rst_ld_busy", ld_busy_o, 0);
    chk("rst_wait_n", wait_n_o, 1);

    // table of single CPU accesses; strobe held 10 cycles past completion
    foreach (tv[i]) begin
      dly = tv[i].dl;
      rdata = tv[i].rd;
      c0 = req_cnt;
      cpu_go(tv[i].kind, tv[i].ca, tv[i].ra, tv[i].wd, wc);
      chk($sformatf("v%0d_wait_cycles", i), wc, tv[i].ewait);
      chk($sformatf("v%0d_mem_a", i), log_a, tv[i].ea);
      chk($sformatf("v%0d_mem_we", i), log_we, tv[i].ewe);
      if (tv[i].ewe) chk($sformatf("v%0d_mem_d", i), log_d, tv[i].wd);
      chk($sformatf("v%0d_cpu_d", i), cpu_d_o, tv[i].ecd);
      for (int n = 0; n < 10; n++) tick();
      chk($sformatf("v%0d_one_request", i), req_cnt - c0, 1);
      cpu_idle();
      tick();
    end

    // loader write, second pulse while busy is dropped
    dly = 2;
    c0 = req_cnt;
    ld_a_i = 21'h000010; ld_d_i = 8'h11; ld_wr_i = 1'b1;
    #1 chk("ld_busy_before", ld_busy_o, 0);
    tick();
    chk("ld_busy_rise", ld_busy_o, 1);
    ld_a_i = 21'h000020; ld_d_i = 8'h22;
    tick();
    ld_wr_i = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (mem_ack_i) break;
      tick();
    end
    chk("ld_ack_seen", mem_ack_i, 1);
    chk("ld_busy_at_ack", ld_busy_o, 1);
    tick();
    chk("ld_busy_after_ack", ld_busy_o, 0);
    chk("ld_mem_a", log_a, 21'h000010);
    chk("ld_mem_d", log_d, 8'h11);
    chk("ld_mem_we", log_we, 1);
    for (int n = 0; n < 6; n++) tick();
    chk("ld_second_dropped", req_cnt - c0, 1);

    // CPU and loader arrive together, four times
    dly = 1;
    for (int i = 0; i < 4; i++) begin
      q0 = grant_q.size();
      rdata = 8'h40 + 8'(i);
      cart_rd_i = 1'b1; cart_a_i = 20'h00100 + 20'(i);
      ld_wr_i = 1'b1; ld_a_i = 21'h000300 + 21'(i); ld_d_i = 8'(i);
      #1;
      wc = 0;
      for (int n = 0; n < 40; n++) begin
        if (wait_n_o) break;
        wc++;
        tick();
        ld_wr_i = 1'b0;
      end
      ld_wr_i = 1'b0;
      cart_rd_i = 1'b0;
      for (int n = 0; n < 40; n++) begin
        if (!ld_busy_o) break;
        tick();
      end
      tick();
      chk($sformatf("tie%0d_cpu_wait_bound", i), (wc <= 4), 1);
      chk($sformatf("tie%0d_grants", i), grant_q.size() - q0, 2);
      if (grant_q.size() >= q0 + 2) begin
        chk($sformatf("tie%0d_first_cpu", i), grant_q[q0], 21'h000100 + 21'(i));
        chk($sformatf("tie%0d_second_ld", i), grant_q[q0+1], 21'h000300 + 21'(i));
      end
      chk($sformatf("tie%0d_cpu_d", i), cpu_d_o, 8'h40 + 8'(i));
    end

    // reset while a CPU access is outstanding
    dly = 20;
    cart_rd_i = 1'b1; cart_a_i = 20'h00042;
    tick();
    chk("rstmid_req_up", mem_req_o, 1);
    reset_n_s = 1'b0;
    #1;
    chk("rstmid_req_drop", mem_req_o, 0);
    chk("rstmid_cpu_d", cpu_d_o, 8'hFF);
    cart_rd_i = 1'b0;
    tick();
    reset_n_s = 1'b1;
    tick();
    dly = 1; rdata = 8'h96;
    cpu_go(0, 20'h00042, 15'h0, 8'h0, wc);
    chk("rstmid_next_wait", wc, 3);
    chk("rstmid_next_cpu_d", cpu_d_o, 8'h96);
    chk("rstmid_next_a", log_a, 21'h000042);
    cpu_idle();
    tick();

    // strobe drops mid-access
    dly = 3; rdata = 8'hE1;
    c0 = req_cnt;
    cart_rd_i = 1'b1; cart_a_i = 20'h00555;
    tick();
    tick();
    cart_rd_i = 1'b0;
    #1 chk("drop_wait_released", wait_n_o, 1);
    for (int n = 0; n < 40; n++) begin
      if (req_cnt != c0) break;
      tick();
    end
    tick();
    chk("drop_access_done", req_cnt - c0, 1);
    chk("drop_cpu_d", cpu_d_o, 8'hE1);
    dly = 0; rdata = 8'h1E;
    cpu_go(0, 20'h00556, 15'h0, 8'h0, wc);
    chk("drop_fresh_wait", wc, 2);
    chk("drop_fresh_cpu_d", cpu_d_o, 8'h1E);
    chk("drop_fresh_req", req_cnt - c0, 2);
    cpu_idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
